serial_adder: RTL and testbench

- Bit-serial N-bit add/subtract unit built around a single one-bit full-adder cell plus a registered carry.
- Sits directly around the full-adder cell: it sequences operand bits LSB-first into the cell and collects the sum and carry bits it produces.
- Trades area for latency, one result bit per clock, in keeping with the gate-level Slipstream arithmetic.
- Feeds a result register with a DONE strobe to the consuming datapath.

---
 rtl/serial_adder.sv | 134 +++++++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit add/subtract unit built around a single
// one-bit full-adder cell and a registered carry. Operands are shifted through
// the cell LSB-first, one result bit per clock, and the finished result is
// presented together with a one-cycle DONE strobe.
//
// Ports:
//   CLK     in   system clock, rising edge
//   RESETL  in   synchronous active-low reset
//   START   in   request, accepted in IDLE or DONE
//   SUB     in   0: A+B+CIN, 1: A-B (CIN ignored); sampled with START
//   CIN     in   carry-in for add mode; sampled with START
//   OPA     in   operand A; sampled with START
//   OPB     in   operand B; sampled with START
//   BUSY    out  high while an operation is running
//   DONE    out  one-cycle result-valid pulse
//   SUM     out  result, held until the next completion
//   COUT    out  final carry out (subtract: 1 = no borrow)
//   OVF     out  signed overflow
module serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESETL,
    input  logic             START,
    input  logic             SUB,
    input  logic             CIN,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned RES_W = WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    // Holds the first WIDTH-1 result bits; the last bit goes straight to SUM.
    logic [RES_W-1:0]   res_q;
    logic               carry_q;
    logic               cmsb_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    // One-bit full-adder cell fed by the operand LSBs and the running carry.
    logic fa_q_c;
    logic fa_co_c;

    always_comb begin
        fa_q_c  = a_q[0] ^ b_q[0] ^ carry_q;
        fa_co_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    end

    // Sequencer, datapath and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RESETL) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        // Subtract is A + ~B + 1.
                        a_q     <= OPA;
                        b_q     <= SUB ? ~OPB : OPB;
                        carry_q <= SUB ? 1'b1 : CIN;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= RES_W'({fa_q_c, res_q} >> 1);
                    carry_q <= fa_co_c;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    // Carry into the MSB, needed for signed overflow.
                    if (cnt_q == CNT_W'(WIDTH - 2)) begin
                        cmsb_q <= fa_co_c;
                    end
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        sum_q   <= {fa_q_c, res_q};
                        cout_q  <= fa_co_c;
                        ovf_q   <= cmsb_q ^ fa_co_c;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign SUM  = sum_q;
    assign COUT = cout_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=16): directed vectors with hand-computed
// results pushed to a scoreboard queue; a monitor pops on every DONE pulse.
module tb_serial_adder;

    localparam int unsigned WIDTH = 16;

    logic             CLK;
    logic             RESETL;
    logic             START;
    logic             SUB;
    logic             CIN;
    logic [WIDTH-1:0] OPA;
    logic [WIDTH-1:0] OPB;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             OVF;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .CLK    (CLK),
        .RESETL (RESETL),
        .START  (START),
        .SUB    (SUB),
        .CIN    (CIN),
        .OPA    (OPA),
        .OPB    (OPB),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .SUM    (SUM),
        .COUT   (COUT),
        .OVF    (OVF)
    );

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t             sb_q[$];
    int               total = 0;
    int               bad   = 0;
    logic [WIDTH-1:0] last_sum = '0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive a request; the caller's next clock edge samples it.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input logic cin, input bit push,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        exp_t e;
        OPA   = a;
        OPB   = b;
        SUB   = sub;
        CIN   = cin;
        START = 1'b1;
        if (push) begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo;
            sb_q.push_back(e);
        end
    endtask

    // Accept edge, WIDTH-1 busy edges, then the DONE edge. pulse_at>0 re-pulses
    // START (with different operands) so it is sampled at that RUN edge.
    task automatic run(input string name, input int pulse_at, input bit chk_accept,
                       input logic [WIDTH-1:0] exp_sum);
        tick();
        START = 1'b0;
        OPA = 16'hDEAD; OPB = 16'hBEEF; SUB = 1'b1; CIN = 1'b0;
        if (chk_accept) chk({name, "_busy_at_accept"}, 32'(BUSY), 32'd1);
        for (int i = 1; i < WIDTH; i++) begin
            tick();
            START = 1'b0;
            if (i == pulse_at - 1) begin
                START = 1'b1;
                OPA   = 16'hAAAA;
            end
            if (i == 1 || i == WIDTH / 2 || i == WIDTH - 1) begin
                chk({name, "_busy"}, 32'(BUSY), 32'd1);
                chk({name, "_nodone"}, 32'(DONE), 32'd0);
            end
            if (i == WIDTH / 2) chk({name, "_sum_held"}, 32'(SUM), 32'(last_sum));
        end
        tick();
        chk({name, "_done"}, 32'(DONE), 32'd1);
        chk({name, "_busy_in_done"}, 32'(BUSY), 32'd0);
        last_sum = exp_sum;
    endtask

    // Scoreboard monitor: every DONE must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got DONE=1 expected no pending result (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_sum",  32'(SUM),  32'(e.sum));
                    chk("sb_cout", 32'(COUT), 32'(e.cout));
                    chk("sb_ovf",  32'(OVF),  32'(e.ovf));
                end
            end
        end
    end

    initial begin
        RESETL = 1'b0; START = 1'b0; SUB = 1'b0; CIN = 1'b0; OPA = '0; OPB = '0;
        tick();
        tick();
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_sum",  32'(SUM),  32'd0);
        chk("rst_cout", 32'(COUT), 32'd0);
        chk("rst_ovf",  32'(OVF),  32'd0);
        RESETL = 1'b1;
        tick();

        // Plain add
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
        run("add", 0, 1'b0, 16'h5555);
        tick();
        chk("idle_after_done", 32'(DONE), 32'd0);

        // Carry-in ripples through all ones
        issue(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        run("cin", 0, 1'b0, 16'h0000);
        tick();
        // Positive overflow
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        run("ovf", 0, 1'b0, 16'h8000);
        tick();

        // Subtract with borrow; CIN ignored
        issue(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run("sub_borrow", 0, 1'b0, 16'hFFFE);
        tick();
        // Subtract with negative overflow
        issue(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run("sub_ovf", 0, 1'b0, 16'h7FFF);
        tick();

        // START during RUN is ignored
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
        run("ign_start", 5, 1'b0, 16'h5555);
        tick();
        chk("ign_single_done", 32'(DONE), 32'd0);

        // Back-to-back: START held through the DONE cycle
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
        run("b2b_first", 0, 1'b0, 16'h0002);
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        run("b2b_second", 0, 1'b1, 16'hFFFE);
        tick();

        // Reset at RUN edge 8 aborts with no DONE
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        START = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        RESETL = 1'b0;
        tick();
        RESETL = 1'b1;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_sum",  32'(SUM),  32'd0);
        chk("abort_cout", 32'(COUT), 32'd0);
        chk("abort_ovf",  32'(OVF),  32'd0);
        last_sum = '0;
        for (int i = 0; i < 20; i++) tick();
        chk("abort_no_done", 32'(DONE), 32'd0);

        // Fresh run after abort
        issue(16'h00FF, 16'h0F0F, 1'b0, 1'b0, 1'b1, 16'h100E, 1'b0, 1'b0);
        run("after_abort", 0, 1'b0, 16'h100E);
        tick();
        tick();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
